aes_key_expand: RTL and testbench

AES-128 key schedule generator (FIPS-197 §5.2). Accepts a 128-bit cipher key and streams the 11 round keys, one per cycle, to the round datapath. It sits directly upstream of the round/AddRoundKey stage. It computes SubWord through four instances of the team's combinational byte S-box.

---
 rtl/aes_pkg.sv | 20 ++
 rtl/aes_sbox.sv | 28 ++
 rtl/aes_sub_word.sv | 16 +
 rtl/aes_key_expand.sv | 107 ++++++++++
 tb/tb_aes_key_expand.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and constants for the key schedule and round datapath.
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] key_t;

  typedef enum logic {IDLE, EXPAND} kx_state_t;

  localparam int NR_128 = 10;

  localparam logic [7:0] RCON [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // RotWord: cyclic left rotation by one byte.
  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in and one byte out.
module aes_sbox (
  input  logic [7:0] byte_val,
  output logic [7:0] sub_val
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign sub_val = SBOX[byte_val];

endmodule

// File: rtl/aes_sub_word.sv
// SubWord: applies the byte S-box to each of the four bytes of a word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] w,
  output logic [31:0] sw
);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .byte_val (w[8*b +: 8]),
      .sub_val  (sw[8*b +: 8])
    );
  end

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: streams round keys 0..NR, one per cycle, after a start pulse.
// Optional round-key store with registered read port: define AES_KEY_STORE_EN.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NR = NR_128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  output logic [3:0]   rk_idx,
  output logic [127:0] rk_out,
  output logic         done
`ifdef AES_KEY_STORE_EN
  ,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
`endif
);

  if (NR != NR_128) begin : g_nr_check
    $error("aes_key_expand supports only NR = 10 (AES-128)");
  end

  localparam logic [3:0] LAST = 4'(NR);

  kx_state_t  state;
  logic [3:0] rcon_idx;
  word_t      w0, w1, w2, w3, sub_rot, t;
  word_t      n0, n1, n2, n3;
  logic [7:0] rcon_byte;

  assign {w0, w1, w2, w3} = rk_out;

  aes_sub_word u_sub_word (
    .w  (rot_word(w3)),
    .sw (sub_rot)
  );

  // rcon_idx reaches 10 on the final key, where the next-key chain is unused.
  assign rcon_byte = (rcon_idx < 4'd10) ? RCON[rcon_idx] : 8'h00;
  assign t  = sub_rot ^ {rcon_byte, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      rk_idx   <= '0;
      rk_out   <= '0;
      done     <= 1'b0;
      rcon_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= EXPAND;
            busy     <= 1'b1;
            rk_valid <= 1'b1;
            rk_idx   <= '0;
            rk_out   <= key_in;
            rcon_idx <= '0;
            done     <= 1'b0;
          end
        end
        EXPAND: begin
          if (rk_idx == LAST) begin
            state    <= IDLE;
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            done     <= 1'b0;
          end else begin
            rk_out   <= {n0, n1, n2, n3};
            rk_idx   <= rk_idx + 4'd1;
            rcon_idx <= rcon_idx + 4'd1;
            done     <= (rk_idx == LAST - 4'd1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AES_KEY_STORE_EN
  key_t store [0:NR];

  // NOTE: the store is small and must read back 0 after reset, so it is reset like ordinary flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NR; i++) store[i] <= '0;
      rd_key <= '0;
    end else begin
      if (rk_valid) store[rk_idx] <= rk_out;
      rd_key <= (rd_idx <= LAST) ? store[rd_idx] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand using FIPS-197 directed key vectors.
module tb_aes_key_expand;
  import aes_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  key_t         key_in = '0;
  logic         busy, rk_valid, done;
  logic [3:0]   rk_idx;
  key_t         rk_out;
`ifdef AES_KEY_STORE_EN
  logic [3:0]   rd_idx = '0;
  key_t         rd_key;
`endif

  always #5 clk = ~clk;

  aes_key_expand dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_idx   (rk_idx),
    .rk_out   (rk_out),
    .done     (done)
`ifdef AES_KEY_STORE_EN
    ,
    .rd_idx   (rd_idx),
    .rd_key   (rd_key)
`endif
  );

  typedef struct {
    logic [3:0] idx;
    key_t       key;
    bit         chk_key;
    bit         done;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass = 0;
  int   valid_cnt = 0;
  int   done_cnt = 0;

  localparam key_t A1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam key_t Z1     = 128'h62636363626363636263636362636363;
  localparam key_t Z10    = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  key_t a1_tbl [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Queue the expected schedule; the zero-key run only pins indices 0, 1 and 10.
  task automatic push_run(input bit zero_key);
    exp_t e;
    for (int i = 0; i <= 10; i++) begin
      e.idx  = 4'(i);
      e.done = (i == 10);
      if (zero_key) begin
        e.key     = (i == 1) ? Z1 : (i == 10) ? Z10 : '0;
        e.chk_key = (i == 0) || (i == 1) || (i == 10);
      end else begin
        e.key     = a1_tbl[i];
        e.chk_key = 1'b1;
      end
      sb_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rk_valid) begin
        valid_cnt++;
        if (done) done_cnt++;
        if (sb_q.size() == 0) begin
          check("sb_unexpected_valid", {124'h0, rk_idx}, 128'hffff);
        end else begin
          mon_e = sb_q.pop_front();
          check($sformatf("sb_idx[%0d]", mon_e.idx), rk_idx, mon_e.idx);
          if (mon_e.chk_key) check($sformatf("sb_key[%0d]", mon_e.idx), rk_out, mon_e.key);
          check($sformatf("sb_done[%0d]", mon_e.idx), done, mon_e.done);
        end
      end else if (done) begin
        done_cnt++;
        check("sb_done_without_valid", done, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    check("reset_rk_out", rk_out, 0);
    check("reset_ctl", {busy, rk_valid, done, rk_idx}, 0);
    rst_n = 1'b1;
    tick();

    // A.1 run with an ignored restart at idx 3 and a start held through done.
    push_run(0);
    valid_cnt = 0; done_cnt = 0;
    start = 1'b1; key_in = A1_KEY;
    tick();
    start = 1'b0; key_in = {128{1'b1}};
    check("a1_idx0_busy", {busy, rk_valid, rk_idx}, {1'b1, 1'b1, 4'd0});
    repeat (3) tick();
    check("a1_at_idx3", rk_idx, 3);
    start = 1'b1; key_in = 128'h00112233445566778899aabbccddeeff;
    tick();
    start = 1'b0;
    wait_done("a1_done_seen");
    start = 1'b1; key_in = '0;
    push_run(1);
    tick();
    check("a1_post_busy_valid", {busy, rk_valid, done}, 0);
    check("a1_hold_idx", rk_idx, 10);
    check("a1_hold_key", rk_out, a1_tbl[10]);
    check("a1_valid_count", valid_cnt, 11);
    check("a1_done_count", done_cnt, 1);
    valid_cnt = 0; done_cnt = 0;

    // Zero key accepted on the first busy=0 cycle.
    tick();
    start = 1'b0;
    check("zero_idx0_next", {rk_valid, rk_idx}, {1'b1, 4'd0});
    wait_done("zero_done_seen");
    tick();
    check("zero_post_busy", {busy, rk_valid}, 0);
    check("zero_hold_key", rk_out, Z10);
    check("zero_valid_count", valid_cnt, 11);
    check("zero_done_count", done_cnt, 1);

    // Reset at idx 5 aborts without a done pulse.
    push_run(0);
    valid_cnt = 0; done_cnt = 0;
    start = 1'b1; key_in = A1_KEY;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("abort_at_idx5", rk_idx, 5);
    #2 rst_n = 1'b0;
    #1;
    check("abort_rk_out", rk_out, 0);
    check("abort_ctl", {busy, rk_valid, done, rk_idx}, 0);
    sb_q.delete();
    repeat (3) tick();
    check("abort_no_done", done_cnt, 0);
    check("abort_valid_count", valid_cnt, 5);
    rst_n = 1'b1;
    tick();

    // Fresh A.1 run after reset.
    push_run(0);
    valid_cnt = 0; done_cnt = 0;
    start = 1'b1; key_in = A1_KEY;
    tick();
    start = 1'b0;
    check("fresh_idx0", {rk_valid, rk_idx}, {1'b1, 4'd0});
    wait_done("fresh_done_seen");
    tick();
    check("fresh_post_busy", busy, 0);
    check("fresh_valid_count", valid_cnt, 11);
    check("fresh_done_count", done_cnt, 1);

`ifdef AES_KEY_STORE_EN
    rd_idx = 4'd1;
    tick();
    check("store_rd1", rd_key, a1_tbl[1]);
    rd_idx = 4'd15;
    tick();
    check("store_rd15", rd_key, 0);
    rd_idx = 4'd10;
    tick();
    check("store_rd10", rd_key, a1_tbl[10]);
`endif

    repeat (2) tick();
    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
